// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM port between the instruction and data
// caches of two cores. Round-robin between cores, fixed priority within a
// core (dWEN > dREN > iREN). Data transfers are whole blocks, one word per
// RAM ACCESS beat, with the word index exposed on wordsel.
module mem_bus_arbiter #(
  parameter int NCPU            = 2,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int ADDR_W          = 32,
  parameter int WORD_W          = 32
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic [NCPU-1:0]                    iREN,
  input  logic [NCPU*ADDR_W-1:0]             iaddr,
  output logic [NCPU-1:0]                    iwait,
  output logic [NCPU*WORD_W-1:0]             iload,
  input  logic [NCPU-1:0]                    dREN,
  input  logic [NCPU-1:0]                    dWEN,
  input  logic [NCPU*ADDR_W-1:0]             daddr,
  input  logic [NCPU*WORD_W-1:0]             dstore,
  output logic [NCPU-1:0]                    dwait,
  output logic [NCPU*WORD_W-1:0]             dload,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] wordsel,
  output logic                               ramREN,
  output logic                               ramWEN,
  output logic [ADDR_W-1:0]                  ramaddr,
  output logic [WORD_W-1:0]                  ramstore,
  input  logic [WORD_W-1:0]                  ramload,
  input  logic [1:0]                         ramstate,
  output logic                               grant,
  output logic                               busy
);

  localparam int CNT_W     = $clog2(WORDS_PER_BLOCK);
  localparam int BLK_BYTES = WORDS_PER_BLOCK * 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IFETCH = 2'd1;
  localparam logic [1:0] DREAD  = 2'd2;
  localparam logic [1:0] DWRITE = 2'd3;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_BLOCK - 1);

  logic [1:0]       state;
  logic             last;
  logic [CNT_W-1:0] cnt;

  logic [NCPU-1:0]   req_any;
  logic              cand;
  logic              op_req;
  logic              access;
  logic              beat;
  logic [ADDR_W-1:0] g_iaddr;
  logic [ADDR_W-1:0] g_daddr;
  logic [WORD_W-1:0] g_dstore;
  logic [ADDR_W-1:0] blk_addr;

  assign req_any  = iREN | dREN | dWEN;
  // The core that did not go last gets first pick; otherwise the same core may go again.
  assign cand     = req_any[~last] ? ~last : last;
  assign access   = (ramstate == RAM_ACCESS);
  assign g_iaddr  = iaddr[int'(grant)*ADDR_W +: ADDR_W];
  assign g_daddr  = daddr[int'(grant)*ADDR_W +: ADDR_W];
  assign g_dstore = dstore[int'(grant)*WORD_W +: WORD_W];
  // Block base plus word offset; wraps modulo 2^ADDR_W.
  assign blk_addr = (g_daddr & ~ADDR_W'(BLK_BYTES - 1)) + ADDR_W'({cnt, 2'b00});
  // A beat only completes while the owner still holds the request it was granted for.
  assign beat     = (state != IDLE) && op_req && access;
  assign wordsel  = cnt;
  assign busy     = (state != IDLE);

  // Is the request bit for the granted operation still asserted?
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    op_req = 1'b0;
    case (state)
      IFETCH:  op_req = iREN[grant];
      DREAD:   op_req = dREN[grant];
      DWRITE:  op_req = dWEN[grant];
      default: op_req = 1'b0;
    endcase
  end

  // Arbitration in IDLE, word sequencing and abort handling while busy.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!nRST) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any[cand]) begin
            grant <= cand;
            cnt   <= '0;
            if (dWEN[cand])      state <= DWRITE;
            else if (dREN[cand]) state <= DREAD;
            else                 state <= IFETCH;
          end
        end
        default: begin
          if (!op_req) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= grant;
          end else if (access) begin
            if (state == IFETCH || cnt == LAST_CNT) begin
              state <= IDLE;
              last  <= grant;
            end
            // Final word wraps cnt back to zero since the block size is a power of two.
            if (state != IFETCH) cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // RAM strobes, address/data steering and wait/load outputs for the owning core.
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = g_iaddr;
        iload[int'(grant)*WORD_W +: WORD_W] = ramload;
        if (beat) iwait[grant] = 1'b0;
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = blk_addr;
        dload[int'(grant)*WORD_W +: WORD_W] = ramload;
        if (beat) dwait[grant] = 1'b0;
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = blk_addr;
        ramstore = g_dstore;
        if (beat) dwait[grant] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (NCPU=2, WORDS_PER_BLOCK=2, 32-bit).
// Inputs change 1 time unit after the rising edge; outputs are checked 1
// unit later, well before the next edge.
module tb_mem_bus_arbiter;

  localparam logic [1:0] R_FREE   = 2'd0;
  localparam logic [1:0] R_BUSY   = 2'd1;
  localparam logic [1:0] R_ACCESS = 2'd2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait;
  logic [63:0] iload, dload;
  logic        wordsel;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        grant, busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .wordsel(wordsel),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .grant(grant), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [1:0]  seq_state [4];
  logic [31:0] seq_addr  [4];
  logic [1:0]  seq_dwait [4];

  initial begin
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = R_FREE;

    // ---- reset state
    next_cycle(); next_cycle();
    check("rst_busy",    busy, 1'b0);
    check("rst_wordsel", wordsel, 1'b0);
    check("rst_ramREN",  ramREN, 1'b0);
    check("rst_ramWEN",  ramWEN, 1'b0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check("rst_iwait",   iwait, 2'b11);
    check("rst_dwait",   dwait, 2'b11);
    check("rst_iload",   iload, 64'h0);
    check("rst_dload",   dload, 64'h0);
    check("rst_grant",   grant, 1'b0);

    // ---- reset in the middle of a DREAD with cnt=1
    nRST = 1'b1; dREN = 2'b01; daddr[31:0] = 32'h200;
    next_cycle();                       // DREAD, cnt=0
    ramstate = R_ACCESS; ramload = 32'h1111_2222; settle();
    check("mid_addr0", ramaddr, 32'h200);
    check("mid_dwait0", dwait, 2'b10);
    check("mid_dload0", dload, {32'h0, 32'h1111_2222});
    next_cycle();                       // DREAD, cnt=1
    check("mid_wordsel1", wordsel, 1'b1);
    nRST = 1'b0; ramstate = R_FREE;
    next_cycle();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_wordsel", wordsel, 1'b0);
    check("mid_rst_ramREN", ramREN, 1'b0);
    check("mid_rst_dwait", dwait, 2'b11);
    nRST = 1'b1; dREN = '0; iREN = 2'b01; iaddr[31:0] = 32'h40;
    next_cycle();                       // IFETCH for core 0
    ramstate = R_ACCESS; ramload = 32'hDEAD_BEEF; settle();
    check("post_rst_grant", grant, 1'b0);
    check("post_rst_ramREN", ramREN, 1'b1);
    check("post_rst_addr", ramaddr, 32'h40);
    check("post_rst_iwait", iwait, 2'b10);
    check("post_rst_iload", iload, {32'h0, 32'hDEAD_BEEF});
    next_cycle();
    iREN = '0; settle();
    check("post_rst_idle", busy, 1'b0);

    // ---- core 1 lone fetch at 0x100, ACCESS on the first strobe cycle
    iREN = 2'b10; iaddr[63:32] = 32'h100; ramstate = R_ACCESS;
    next_cycle();
    check("c1_grant", grant, 1'b1);
    check("c1_addr", ramaddr, 32'h100);
    check("c1_iwait", iwait, 2'b01);
    check("c1_iload", iload, {32'hDEAD_BEEF, 32'h0});
    next_cycle();
    iREN = '0; settle();
    check("c1_busy_drop", busy, 1'b0);
    check("c1_iwait_idle", iwait, 2'b11);

    // ---- both cores fetching continuously: 0,1,0,1 with one IDLE between
    iREN = 2'b11; iaddr = {32'h600, 32'h700}; ramstate = R_ACCESS;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      check($sformatf("rr_busy_%0d", k), busy, (k % 2) == 0);
      if ((k % 2) == 0)
        check($sformatf("rr_grant_%0d", k), grant, ((k / 2) % 2) == 1);
    end
    iREN = '0;

    // ---- core 0 block read at 0x20C, RAM BUSY,ACCESS,BUSY,ACCESS
    dREN = 2'b01; daddr[31:0] = 32'h20C;
    seq_state = '{R_BUSY, R_ACCESS, R_BUSY, R_ACCESS};
    seq_addr  = '{32'h208, 32'h208, 32'h20C, 32'h20C};
    seq_dwait = '{2'b11, 2'b10, 2'b11, 2'b10};
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      ramstate = seq_state[k]; settle();
      check($sformatf("blk_addr_%0d", k + 1), ramaddr, seq_addr[k]);
      check($sformatf("blk_dwait_%0d", k + 1), dwait, seq_dwait[k]);
    end
    next_cycle();
    dREN = '0; settle();
    check("blk_done", busy, 1'b0);

    // ---- core 1 with dWEN and dREN both high: write wins
    dWEN = 2'b10; dREN = 2'b10; daddr[63:32] = 32'h300;
    next_cycle();
    dstore[63:32] = 32'hA0A0_0000; ramstate = R_ACCESS; settle();
    check("wr_ramWEN0", ramWEN, 1'b1);
    check("wr_ramREN0", ramREN, 1'b0);
    check("wr_addr0", ramaddr, 32'h300);
    check("wr_store0", ramstore, 32'hA0A0_0000);
    check("wr_dwait0", dwait, 2'b01);
    check("wr_dload0", dload, 64'h0);
    next_cycle();
    dstore[63:32] = 32'hB1B1_1111; settle();
    check("wr_wordsel1", wordsel, 1'b1);
    check("wr_ramWEN1", ramWEN, 1'b1);
    check("wr_ramREN1", ramREN, 1'b0);
    check("wr_addr1", ramaddr, 32'h304);
    check("wr_store1", ramstore, 32'hB1B1_1111);
    next_cycle();
    dWEN = '0; dREN = '0; settle();
    check("wr_done", busy, 1'b0);

    // ---- core 0 aborts after its first word; pending fetch from core 1
    dREN = 2'b01; daddr[31:0] = 32'h400; iREN = 2'b10; iaddr[63:32] = 32'h500;
    next_cycle();
    ramstate = R_ACCESS; settle();
    check("ab_grant", grant, 1'b0);
    check("ab_dwait0", dwait, 2'b10);
    next_cycle();
    dREN = '0; settle();
    check("ab_wordsel", wordsel, 1'b1);
    check("ab_no_pulse", dwait, 2'b11);
    next_cycle();
    check("ab_idle", busy, 1'b0);
    check("ab_cnt_clr", wordsel, 1'b0);
    next_cycle();
    check("ab_next_grant", grant, 1'b1);
    check("ab_next_addr", ramaddr, 32'h500);
    check("ab_next_iwait", iwait, 2'b01);
    next_cycle();
    iREN = '0; settle();
    check("ab_final_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares the single RAM port between two cores' instruction and data caches.
- Picks one request per transaction using round-robin priority across cores and fixed priority within a core.
- Sequences multi-word data-block transfers with an internal word counter and generates per-word addresses.
- Sits between the per-core cache pair and RAM, in the memory path beside the coherency controller (it handles raw RAM access; coherency handling stays in the controller).

## Interface
Parameters:
- NCPU, 2: number of cores; arbitration is defined for 2 only.
- WORDS_PER_BLOCK, 2: words per data block; power of two, ≥2.
- ADDR_W, 32: byte-address width.
- WORD_W, 32: data word width.

Ports:
- CLK  in  1  clock; everything is sampled on its rising edge.
- nRST  in  1  reset; synchronous, active-low.
- iREN  in  NCPU  instruction-fetch request, one bit per core.
- iaddr  in  NCPU*ADDR_W  fetch address; core i uses slice i.
- iwait  out  NCPU  0 for one cycle when the fetched word is on iload.
- iload  out  NCPU*WORD_W  fetched word for core i.
- dREN  in  NCPU  data block read request.
- dWEN  in  NCPU  data block write (writeback) request.
- daddr  in  NCPU*ADDR_W  any byte address inside the requested block.
- dstore  in  NCPU*WORD_W  write data for the word selected by wordsel.
- dwait  out  NCPU  0 for one cycle per completed data word.
- dload  out  NCPU*WORD_W  read word for core i.
- wordsel  out  log2(WORDS_PER_BLOCK)  index of the current word of the granted data transfer.
- ramREN, ramWEN  out  1  RAM read and write strobes.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- grant  out  1  core currently owning the bus.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, IFETCH, DREAD, DWRITE.
- Registered state: state, grant, last (the last core served), cnt (word counter).
- Arbitration happens in IDLE only:
  - The candidate core is ~last if that core has any request; otherwise it is last.
  - Within the chosen core, priority is dWEN, then dREN, then iREN. Simultaneous dWEN and dREN from one core resolves to dWEN.
  - On a grant, latch grant and the operation, and clear cnt.
- IFETCH:
  - ramaddr = iaddr[grant], ramREN = 1.
  - iload[grant] = ramload.
  - On ACCESS: pulse iwait[grant] low and go to IDLE.
- DREAD:
  - ramaddr = the block base of daddr[grant] (low log2(WORDS_PER_BLOCK)+2 bits cleared) plus 4*cnt.
  - ramREN = 1, dload[grant] = ramload.
  - On ACCESS: pulse dwait[grant] low and increment cnt. If cnt == WORDS_PER_BLOCK-1, go to IDLE.
- DWRITE: same as DREAD, but drives ramWEN = 1 and ramstore = dstore[grant].
- wordsel always equals cnt.
- On each return to IDLE, set last to grant.
- BUSY, FREE and ERROR all hold the current word and keep the wait line high. ERROR is never reported upward.
- Abort: if the granted core drops its request bit for the current operation mid-transfer:
  - Go to IDLE next cycle and clear cnt.
  - Set last to grant.
  - No wait pulse is issued that cycle.
- Non-granted cores:
  - Wait lines stay 1.
  - Load outputs are 0.
- All wait outputs are 1 in IDLE.
- RAM strobes are 0 in IDLE and are never both high at once.
- Reset (nRST low at a clock edge), including mid-transfer:
  - State goes to IDLE.
  - grant=0, last=1, so core 0 wins the first tie.
  - cnt=0, so wordsel=0.
  - busy=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - All iwait/dwait=1, all iload/dload=0.

## Timing
- Outputs are combinational from the registered state, grant and cnt plus live inputs.
- Request sampled in IDLE at cycle t: the RAM strobe is asserted at t+1.
- Earliest completion is at t+1, if ramstate==ACCESS in that cycle.
- A data block needs at least WORDS_PER_BLOCK ACCESS beats, one word per beat. The counter advances only on ACCESS.
- Completion at cycle u puts the block in IDLE at u+1, a mandatory one-cycle bubble. Re-arbitration happens at u+1 and the next strobe appears at u+2.
- Requesters hold their request, address and dstore until their wait line goes low on the final word. dstore must follow wordsel.
- The address computation wraps modulo 2^ADDR_W; the block base never crosses block alignment.

## Test plan
- Reset during a DREAD with cnt=1:
  - Required next cycle: busy=0, wordsel=0, ramREN=0, dwait=2'b11.
  - Then a lone iREN[0] must be granted to core 0.
- Core 1 only, iREN=1, iaddr=0x100, RAM gives ACCESS on the first strobe cycle:
  - ramaddr=0x100 and iwait[1]=0 for exactly one cycle.
  - busy drops the next cycle.
- Both cores request fetches continuously:
  - Grants alternate 0,1,0,1.
  - Each grant is separated by one IDLE cycle.
- Core 0 dREN, daddr=0x20C, RAM cycles BUSY,ACCESS,BUSY,ACCESS:
  - ramaddr=0x208 then 0x20C.
  - dwait[0] is low on cycles 2 and 4 only.
- Core 1 with dWEN and dREN both high:
  - DWRITE is chosen.
  - ramstore tracks dstore[1] per wordsel.
  - ramWEN=1, ramREN=0 throughout.
- Core 0 drops dREN after its first word:
  - IDLE next cycle with cnt=0.
  - A pending iREN[1] is granted the cycle after that.
